// File: rtl/lsu_data_mem.sv
// Byte-addressable data memory behind a load/store request/response handshake.
// Any power-of-two access size up to XLEN; word-straddling accesses optionally split into two beats.
module lsu_data_mem #(
    parameter int XLEN             = 32,
    parameter int DEPTH_WORDS      = 1024,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_write_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_fault_o
);

    localparam int W    = XLEN / 8;
    localparam int OFFW = $clog2(W);
    localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [OFFW-1:0]     off_q;
    logic [AW-1:0]       widx_q;
    logic [1:0]          size_q;
    logic                write_q;
    logic                uns_q;
    logic                cross_q;
    logic [XLEN-1:0]     wdata_q;
    logic [W-1:0][7:0]   rbuf_q, rbuf_d;

    logic                resp_valid_q, resp_valid_d;
    logic                resp_fault_q, resp_fault_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;

    // ---------------- request decode ----------------
    logic                accept;
    logic [4:0]          req_nbytes;
    logic [OFFW-1:0]     req_off;
    logic [XLEN-1:0]     req_widx;
    logic                req_cross, req_too_big, req_range, req_fault;

    assign req_ready_o = (state_q == S_IDLE) && !reset_i;
    assign accept      = req_valid_i && req_ready_o;

    assign req_nbytes  = 5'd1 << req_size_i;
    assign req_off     = req_addr_i[OFFW-1:0];
    assign req_widx    = req_addr_i >> OFFW;
    assign req_too_big = req_nbytes > 5'(W);
    assign req_cross   = (5'(req_off) + req_nbytes) > 5'(W);
    // A split touches word i+1 as well, so the last word cannot start one.
    assign req_range   = (req_widx >= XLEN'(DEPTH_WORDS)) ||
                         (req_cross && (req_widx >= XLEN'(DEPTH_WORDS - 1)));
    assign req_fault   = req_too_big || (req_cross && (ALLOW_MISALIGNED == 0)) || req_range;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            off_q   <= req_off;
            widx_q  <= req_widx[AW-1:0];
            size_q  <= req_size_i;
            write_q <= req_write_i;
            uns_q   <= req_unsigned_i;
            cross_q <= req_cross;
            wdata_q <= req_wdata_i;
        end
    end

    // ---------------- beat datapath ----------------
    logic                in_beat, beat1;
    logic [AW-1:0]       widx_cur;
    logic [XLEN-1:0]     word_cur;
    logic [4:0]          nbytes_q;
    logic [W-1:0]        be;
    logic [W-1:0][OFFW-1:0] kidx;
    logic [W-1:0][7:0]   wbyte;

    assign in_beat  = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign beat1    = (state_q == S_BEAT1);
    assign widx_cur = beat1 ? widx_q + AW'(1) : widx_q;
    assign word_cur = mem[widx_cur];
    assign nbytes_q = 5'd1 << size_q;

    // Map each byte lane of the current word to its position k in the access.
    always_comb begin
        logic [4:0] k;
        be    = '0;
        kidx  = '0;
        wbyte = '0;
        for (int b = 0; b < W; b++) begin
            k = beat1 ? 5'(b) + 5'(W) - 5'(off_q) : 5'(b) - 5'(off_q);
            be[b]    = in_beat && (k < nbytes_q) && (beat1 || (5'(b) >= 5'(off_q)));
            kidx[b]  = k[OFFW-1:0];
            wbyte[b] = wdata_q[8*kidx[b] +: 8];
        end
    end

    always_comb begin
        rbuf_d = rbuf_q;
        for (int b = 0; b < W; b++)
            if (be[b] && !write_q) rbuf_d[kidx[b]] = word_cur[8*b +: 8];
    end

    always_ff @(posedge clk_i) begin
        rbuf_q <= rbuf_d;
    end

    // A beat closing on a reset edge must not modify memory.
    always_ff @(posedge clk_i) begin
        if (!reset_i && write_q) begin
            for (int b = 0; b < W; b++)
                if (be[b]) mem[widx_cur][8*b +: 8] <= wbyte[b];
        end
    end

    // ---------------- load extension ----------------
    logic [XLEN-1:0] raw, ext;
    logic            sgn;

    assign raw = rbuf_d;

    always_comb begin
        case (size_q)
            2'd0:    sgn = raw[7];
            2'd1:    sgn = raw[15];
            2'd2:    sgn = raw[31];
            default: sgn = raw[XLEN-1];
        endcase
        sgn = sgn && !uns_q;
        ext = raw;
        for (int i = 0; i < XLEN; i++)
            if (i >= (8 << size_q)) ext[i] = sgn;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = S_BEAT0;
                    end
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (state_q == S_BEAT0 && cross_q) begin
                    state_d = S_BEAT1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = write_q ? '0 : ext;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_fault_o = resp_fault_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: one split-capable and one strict-alignment instance,
// 64-word memories so the top-of-memory boundary is at 0x100.
module tb_lsu_data_mem;

    logic        clk;
    logic        reset;
    logic        req_valid_m, req_valid_a;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic        resp_ready;

    logic        req_ready_m, resp_valid_m, resp_fault_m;
    logic [31:0] resp_rdata_m;
    logic        req_ready_a, resp_valid_a, resp_fault_a;
    logic [31:0] resp_rdata_a;

    int tests = 0;
    int fails = 0;

    lsu_data_mem #(.XLEN(32), .DEPTH_WORDS(64), .ALLOW_MISALIGNED(1)) dut_m (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid_m), .req_ready_o(req_ready_m),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid_m), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata_m), .resp_fault_o(resp_fault_m)
    );

    lsu_data_mem #(.XLEN(32), .DEPTH_WORDS(64), .ALLOW_MISALIGNED(0)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata_a), .resp_fault_o(resp_fault_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        sel;   // 1 = split-capable instance, 0 = strict instance
    logic        cur_ready, cur_valid, cur_fault;
    logic [31:0] cur_rdata;
    assign cur_ready = sel ? req_ready_m  : req_ready_a;
    assign cur_valid = sel ? resp_valid_m : resp_valid_a;
    assign cur_fault = sel ? resp_fault_m : resp_fault_a;
    assign cur_rdata = sel ? resp_rdata_m : resp_rdata_a;

    typedef struct {
        string       name;
        logic        sel;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic s, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] er, input logic ef, input int el);
        vec_t v;
        v.name = name; v.sel = s; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, wait for its response, consume it. Latency counts cycles after accept.
    task automatic run(input vec_t v, output logic [31:0] rd, output logic f, output int lat);
        int n;
        sel = v.sel;
        req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        req_valid_m = v.sel; req_valid_a = !v.sel;
        #0;
        n = 0;
        while (!cur_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid_m = 1'b0; req_valid_a = 1'b0;
        lat = 1;
        while (!cur_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = cur_rdata;
        f  = cur_fault;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        f;
        int          lat, n;
        vec_t        v;

        sel = 1'b1; reset = 1'b1; resp_ready = 1'b1;
        req_valid_m = 0; req_valid_a = 0; req_write = 0; req_size = 0;
        req_unsigned = 0; req_addr = 0; req_wdata = 0;

        //   name           sel w  sz  u  addr    wdata         rdata         flt lat
        add("st_w_10",      1, 1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
        add("ld_w_10",      1, 0, 2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
        add("ld_bs_13",     1, 0, 0, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2);
        add("ld_bu_13",     1, 0, 0, 1, 32'h13, 32'h0,        32'h000000DE, 0, 2);
        add("ld_hs_12",     1, 0, 1, 0, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2);
        add("st_b_11",      1, 1, 0, 0, 32'h11, 32'hCAFE0055, 32'h0,        0, 2);
        add("ld_w_10b",     1, 0, 2, 0, 32'h10, 32'h0,        32'hDEAD55EF, 0, 2);
        add("ld_hs_11",     1, 0, 1, 0, 32'h11, 32'h0,        32'hFFFFAD55, 0, 2);
        add("clr_20",       1, 1, 2, 0, 32'h20, 32'h0,        32'h0,        0, 2);
        add("clr_24",       1, 1, 2, 0, 32'h24, 32'h0,        32'h0,        0, 2);
        add("st_w_22",      1, 1, 2, 0, 32'h22, 32'h11223344, 32'h0,        0, 3);
        add("ld_w_22",      1, 0, 2, 0, 32'h22, 32'h0,        32'h11223344, 0, 3);
        add("ld_w_20",      1, 0, 2, 0, 32'h20, 32'h0,        32'h33440000, 0, 2);
        add("ld_w_24",      1, 0, 2, 0, 32'h24, 32'h0,        32'h00001122, 0, 2);
        add("ld_hu_23",     1, 0, 1, 1, 32'h23, 32'h0,        32'h00002233, 0, 3);
        add("clr_fc",       1, 1, 2, 0, 32'hFC, 32'h0,        32'h0,        0, 2);
        add("st_w_fe",      1, 1, 2, 0, 32'hFE, 32'hFFFFFFFF, 32'h0,        1, 1);
        add("ld_w_fc",      1, 0, 2, 0, 32'hFC, 32'h0,        32'h0,        0, 2);
        add("ld_w_100",     1, 0, 2, 0, 32'h100,32'h0,        32'h0,        1, 1);
        add("ld_d_0",       1, 0, 3, 0, 32'h0,  32'h0,        32'h0,        1, 1);
        add("a_st_20",      0, 1, 2, 0, 32'h20, 32'hAAAAAAAA, 32'h0,        0, 2);
        add("a_st_24",      0, 1, 2, 0, 32'h24, 32'hBBBBBBBB, 32'h0,        0, 2);
        add("a_st_w_22",    0, 1, 2, 0, 32'h22, 32'h11223344, 32'h0,        1, 1);
        add("a_ld_w_20",    0, 0, 2, 0, 32'h20, 32'h0,        32'hAAAAAAAA, 0, 2);
        add("a_ld_w_24",    0, 0, 2, 0, 32'h24, 32'h0,        32'hBBBBBBBB, 0, 2);
        add("a_ld_hu_21",   0, 0, 1, 1, 32'h21, 32'h0,        32'h0000AAAA, 0, 2);
        add("a_ld_h_23",    0, 0, 1, 0, 32'h23, 32'h0,        32'h0,        1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_m", 32'(req_ready_m),  32'h0);
        chk("rst_ready_a", 32'(req_ready_a),  32'h0);
        chk("rst_valid",   32'(resp_valid_m), 32'h0);
        chk("rst_rdata",   resp_rdata_m,      32'h0);
        chk("rst_fault",   32'(resp_fault_m), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready_m), 32'h1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            run(v, rd, f, lat);
            chk({v.name, "_rdata"}, rd, v.exp_rdata);
            chk({v.name, "_fault"}, 32'(f), 32'(v.exp_fault));
            chk({v.name, "_lat"},   32'(lat), 32'(v.exp_lat));
        end

        // Response held under back-pressure
        sel = 1'b1;
        req_write = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h10; req_valid_m = 1;
        @(posedge clk); #1;
        req_valid_m = 0; resp_ready = 0;
        n = 0;
        while (!resp_valid_m && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("hold_rdata", resp_rdata_m,      32'hDEAD55EF);
            chk("hold_valid", 32'(resp_valid_m), 32'h1);
            chk("hold_ready", 32'(req_ready_m),  32'h0);
            @(posedge clk); #1;
        end
        resp_ready = 1;
        @(posedge clk); #1;
        chk("hold_done_valid", 32'(resp_valid_m), 32'h0);
        chk("hold_done_ready", 32'(req_ready_m),  32'h1);

        // Reset during BEAT1 of a split store
        add("clr_30", 1, 1, 2, 0, 32'h30, 32'h0, 32'h0, 0, 2);
        add("clr_34", 1, 1, 2, 0, 32'h34, 32'h0, 32'h0, 0, 2);
        run(vecs[vecs.size()-2], rd, f, lat);
        run(vecs[vecs.size()-1], rd, f, lat);
        req_write = 1; req_size = 2; req_addr = 32'h32; req_wdata = 32'hA1B2C3D4; req_valid_m = 1;
        @(posedge clk); #1;         // accept
        req_valid_m = 0;
        @(posedge clk); #1;         // BEAT0 closed, now in BEAT1
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_b1_valid", 32'(resp_valid_m), 32'h0);
        chk("rst_b1_rdata", resp_rdata_m,      32'h0);
        chk("rst_b1_fault", 32'(resp_fault_m), 32'h0);
        chk("rst_b1_ready", 32'(req_ready_m),  32'h0);
        reset = 1'b0;
        #1;
        chk("rst_b1_ready_after", 32'(req_ready_m), 32'h1);
        @(posedge clk); #1;
        add("rst_ld_30", 1, 0, 2, 0, 32'h30, 32'h0, 32'hC3D40000, 0, 2);
        add("rst_ld_34", 1, 0, 2, 0, 32'h34, 32'h0, 32'h00000000, 0, 2);
        for (int i = vecs.size() - 2; i < vecs.size(); i++) begin
            v = vecs[i];
            run(v, rd, f, lat);
            chk({v.name, "_rdata"}, rd, v.exp_rdata);
            chk({v.name, "_fault"}, 32'(f), 32'(v.exp_fault));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_data_mem.md
# lsu_data_mem

Parametrised byte-addressable data memory with a load/store request/response handshake, sitting between the hart's execute stage and its data storage. It generalises the byte/halfword/word write widths to any power-of-two access size up to XLEN. It adds sign/zero-extended loads, range and alignment fault reporting, and optional two-beat handling of accesses that straddle a word boundary. Little-endian throughout.

## Interface
- XLEN, 32: data/address width; 32 or 64 only.
- DEPTH_WORDS, 1024: memory size in XLEN-bit words; power of two.
- ALLOW_MISALIGNED, 1: 1 = word-straddling accesses are split into two beats; 0 = they fault.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE and not in reset.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size 2^req_size bytes (0 byte, 1 half, 2 word, 3 double).
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; low 2^req_size bytes used.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  access rejected; memory unchanged.

## Operation
- W = XLEN/8 bytes per word; word index = req_addr / W; byte offset = req_addr mod W.
- Request accepted on an edge with req_valid && req_ready; addr, size, write, unsigned and wdata are captured then. Inputs are ignored at all other times.
- Fault, decided at acceptance, priority order:
  - 2^req_size > W (size 3 with XLEN=32);
  - misaligned (offset mod 2^size != 0) and the access crosses a word boundary (offset + 2^size > W) with ALLOW_MISALIGNED=0;
  - any touched word index >= DEPTH_WORDS, including the second word of a split.
- A faulting access goes IDLE -> RESP directly with resp_fault=1 and no memory write.
- Misaligned accesses that stay within one word are single-beat and legal.
- FSM:
  - IDLE -> BEAT0 on a non-faulting accept.
  - BEAT0 -> BEAT1 if the access straddles a word, else -> RESP.
  - BEAT1 -> RESP.
  - RESP -> IDLE on resp_ready.
- Per beat: the array word is read combinationally. Stores write only the enabled bytes of that word at the beat's closing edge; other bytes are preserved. Loads collect the addressed bytes into a byte buffer.
- Split access: BEAT0 covers bytes offset..W-1 of word i; BEAT1 covers the remaining low bytes of word i+1.
- Load result: the collected bytes are assembled little-endian, then sign- or zero-extended from bit 8·2^size−1 to XLEN; size = log2(W) passes the data through unchanged.
- The memory array is not cleared by reset; contents are undefined until written.

## Timing
- Reset values: req_ready=0 while reset is high, 1 the cycle after; resp_valid=0, resp_rdata=0, resp_fault=0; FSM=IDLE.
- Accept edge at the end of cycle N. Single-beat: BEAT0 in N+1, resp_valid from N+2. Split: resp_valid from N+3. Fault: resp_valid from N+1.
- A store is visible to a load accepted after its response is consumed.
- resp_* are registered and stable while resp_valid && !resp_ready.
- Throughput: one request per 3 cycles (single-beat, resp_ready tied high). req_ready rises in the cycle after the response handshake.
- Reset mid-operation wins over everything: FSM returns to IDLE and the response is dropped. A store beat whose closing edge coincides with reset is not written. For a split store reset during BEAT1, word i keeps its BEAT0 write and word i+1 is unchanged.

## Test plan
- Store word 0xDEADBEEF at 0x10, load word 0x10 -> resp_rdata=0xDEADBEEF, fault=0; store resp 2 cycles after accept.
- Load byte signed at 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE; half signed at 0x12 -> 0xFFFFDEAD.
- Store byte 0x55 at 0x11 over 0xDEADBEEF -> word at 0x10 reads 0xDEAD55EF.
- ALLOW_MISALIGNED=1: store word 0x11223344 at 0x22, load it back -> 0x11223344; word 0x20 bytes[3:2]=0x3344, word 0x24 bytes[1:0]=0x1122; resp 3 cycles after accept. ALLOW_MISALIGNED=0: same store -> fault=1 after 1 cycle, memory unchanged.
- Address 4·DEPTH_WORDS, and word at 4·DEPTH_WORDS−2 (split) -> fault=1, no write to the last word; size 3 on XLEN=32 -> fault.
- Hold resp_ready=0 for 5 cycles -> resp stable, req_ready=0. Assert reset in BEAT1 of a split store -> only first word modified, outputs zero, req_ready=1 the cycle after reset drops.
